hls_long_tail_bwe_mem_pipe: RTL and testbench

Dual-port, byte-lane-write memory for HLS long-tail kernels. It generalises the plain true-dual-port lane-write RAM with four additions: a parametrised read latency with per-port valid strobes, a selectable read-during-write mode, deterministic cross-port write collision resolution, and a self-clearing initialisation sequence after reset. It sits between HLS-generated array interfaces and the kernel datapath. It replaces fixed-latency wrappers wherever arrays need zeroed contents or extra output pipelining for timing closure.

---
 rtl/hls_long_tail_bwe_mem_pipe_if.sv | 42 ++++
 rtl/hls_long_tail_bwe_mem_pipe.sv | 180 ++++++++++++++++++
 tb/tb_hls_long_tail_bwe_mem_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_long_tail_bwe_mem_pipe_if.sv
// hls_long_tail_bwe_mem_pipe_if
//   Bundles both access ports of the lane-write memory and its init status.
//   master : kernel side (drives ce/we/address/d, receives q/qvld/init_busy)
//   slave  : memory side
//   ce0/ce1             port access enable
//   we0/we1             per-lane write enable (BANK bits)
//   address0/address1   word address (ABITS bits)
//   d0/d1               write data (DBITS bits)
//   q0/q1               read data (DBITS bits)
//   qvld0/qvld1         one-cycle strobe marking new q data
//   init_busy           high while the clear sweep runs
interface hls_long_tail_bwe_mem_pipe_if #(
  parameter int DBITS = 32,
  parameter int BANK  = 4,
  parameter int ABITS = 4
);
  logic             ce0;
  logic [BANK-1:0]  we0;
  logic [ABITS-1:0] address0;
  logic [DBITS-1:0] d0;
  logic [DBITS-1:0] q0;
  logic             qvld0;
  logic             ce1;
  logic [BANK-1:0]  we1;
  logic [ABITS-1:0] address1;
  logic [DBITS-1:0] d1;
  logic [DBITS-1:0] q1;
  logic             qvld1;
  logic             init_busy;

  modport master (
    output ce0, we0, address0, d0,
    output ce1, we1, address1, d1,
    input  q0, qvld0, q1, qvld1, init_busy
  );

  modport slave (
    input  ce0, we0, address0, d0,
    input  ce1, we1, address1, d1,
    output q0, qvld0, q1, qvld1, init_busy
  );
endinterface

// File: rtl/hls_long_tail_bwe_mem_pipe.sv
// hls_long_tail_bwe_mem_pipe
//   True dual-port, byte-lane-write memory for HLS array interfaces with a
//   parametrised read latency, selectable read-during-write behaviour,
//   port-0-wins collision resolution and a zeroing sweep after reset.
//   clk   clock, everything on the rising edge
//   rst   synchronous active-high reset
//   bus   slave modport of hls_long_tail_bwe_mem_pipe_if (both ports + init_busy)
module hls_long_tail_bwe_mem_pipe #(
  parameter int DEPTH      = 16,
  parameter int DBITS      = 32,
  parameter int BANK       = 4,
  parameter int LATENCY    = 1,
  parameter int WR_MODE    = 0,
  parameter int INIT_CLEAR = 1,
  parameter int ABITS      = $clog2(DEPTH)
) (
  input logic                          clk,
  input logic                          rst,
  hls_long_tail_bwe_mem_pipe_if.slave  bus
);

  localparam int LW = DBITS / BANK;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  generate
    if (DBITS % BANK != 0) begin : g_bad_bank
      $fatal(1, "DBITS must be a multiple of BANK");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $fatal(1, "LATENCY must be in 1..4");
    end
  endgenerate

  logic [0:0]       state;
  logic [ABITS-1:0] clr_addr;
  logic             run;

  logic [DBITS-1:0] mem [DEPTH];

  logic             ce       [2];
  logic [BANK-1:0]  we       [2];
  logic [ABITS-1:0] addr     [2];
  logic [DBITS-1:0] din      [2];
  logic [BANK-1:0]  lane_en  [2];
  logic             rd_vld   [2];
  logic [DBITS-1:0] rd_data  [2];
  logic             fin_vld  [2];
  logic [DBITS-1:0] fin_data [2];
  logic             qvld_r   [2];
  logic [DBITS-1:0] q_r      [2];

  assign ce[0]   = bus.ce0;
  assign we[0]   = bus.we0;
  assign addr[0] = bus.address0;
  assign din[0]  = bus.d0;
  assign ce[1]   = bus.ce1;
  assign we[1]   = bus.we1;
  assign addr[1] = bus.address1;
  assign din[1]  = bus.d1;

  assign run = (state == ST_RUN);

  // Ports are only honoured in RUN; during the sweep ce is ignored entirely.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_vld[p]  = run & ce[p];
      lane_en[p] = (run & ce[p]) ? we[p] : '0;
    end
  end

  // Reset always restarts the sweep from address 0; the last cleared word
  // is DEPTH-1, so the exit compare works for non-power-of-two depths too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + ABITS'(1);
      if (clr_addr == ABITS'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  // Port 1 lanes are scheduled before port 0 lanes so that on a same-word,
  // same-lane collision the later non-blocking update (port 0) wins, while
  // disjoint lanes from both ports still land. Contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_addr] <= '0;
      end else begin
        for (int l = 0; l < BANK; l++) begin
          if (lane_en[1][l]) mem[addr[1]][l*LW +: LW] <= din[1][l*LW +: LW];
          if (lane_en[0][l]) mem[addr[0]][l*LW +: LW] <= din[0][l*LW +: LW];
        end
      end
    end
  end

  // Read path sees the pre-edge array, so the other port's same-cycle write
  // always reads as old data. Write-first only overlays this port's own lanes.
  generate
    if (WR_MODE != 0) begin : g_write_first
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          rd_data[p] = mem[addr[p]];
          for (int l = 0; l < BANK; l++) begin
            if (lane_en[p][l]) rd_data[p][l*LW +: LW] = din[p][l*LW +: LW];
          end
        end
      end
    end else begin : g_read_first
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          rd_data[p] = mem[addr[p]];
        end
      end
    end
  endgenerate

  // The q/qvld registers are the last of LATENCY stages, so only LATENCY-1
  // intermediate stages exist; with LATENCY=1 the read feeds q directly.
  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      if (LATENCY == 1) begin : g_direct
        assign fin_vld[p]  = rd_vld[p];
        assign fin_data[p] = rd_data[p];
      end else begin : g_pipe
        logic [LATENCY-2:0] pv;
        logic [DBITS-1:0]   pd [LATENCY-1];

        always_ff @(posedge clk) begin
          if (rst) begin
            pv <= '0;
          end else begin
            pv[0] <= rd_vld[p];
            for (int k = 1; k < LATENCY - 1; k++) begin
              pv[k] <= pv[k-1];
            end
          end
        end

        always_ff @(posedge clk) begin
          pd[0] <= rd_data[p];
          for (int k = 1; k < LATENCY - 1; k++) begin
            pd[k] <= pd[k-1];
          end
        end

        assign fin_vld[p]  = pv[LATENCY-2];
        assign fin_data[p] = pd[LATENCY-2];
      end
    end
  endgenerate

  // q holds its last value between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        qvld_r[p] <= 1'b0;
        q_r[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        qvld_r[p] <= fin_vld[p];
        if (fin_vld[p]) q_r[p] <= fin_data[p];
      end
    end
  end

  assign bus.q0        = q_r[0];
  assign bus.qvld0     = qvld_r[0];
  assign bus.q1        = q_r[1];
  assign bus.qvld1     = qvld_r[1];
  assign bus.init_busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_hls_long_tail_bwe_mem_pipe.sv
// tb_hls_long_tail_bwe_mem_pipe
//   Drives the same directed stimulus into four instances (LATENCY 1..4,
//   WR_MODE alternating 0/1) and checks them against a word/lane-level
//   memory model every cycle, plus hand-computed literal expectations.
module tb_hls_long_tail_bwe_mem_pipe;

  localparam int NI    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        tce [2];
  logic [3:0]  twe [2];
  logic [3:0]  tad [2];
  logic [31:0] td  [2];

  logic [31:0] dq    [NI][2];
  logic        dv    [NI][2];
  logic        dbusy [NI];

  int checks = 0;
  int passes = 0;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      hls_long_tail_bwe_mem_pipe_if #(.DBITS(32), .BANK(4), .ABITS(4)) bus ();

      assign bus.ce0      = tce[0];
      assign bus.we0      = twe[0];
      assign bus.address0 = tad[0];
      assign bus.d0       = td[0];
      assign bus.ce1      = tce[1];
      assign bus.we1      = twe[1];
      assign bus.address1 = tad[1];
      assign bus.d1       = td[1];

      hls_long_tail_bwe_mem_pipe #(
        .DEPTH(DEPTH), .DBITS(32), .BANK(4), .LATENCY(gi + 1),
        .WR_MODE(gi % 2), .INIT_CLEAR(1)
      ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );

      assign dq[gi][0]  = bus.q0;
      assign dv[gi][0]  = bus.qvld0;
      assign dq[gi][1]  = bus.q1;
      assign dv[gi][1]  = bus.qvld1;
      assign dbusy[gi]  = bus.init_busy;
    end
  endgenerate

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Inputs are set just after an edge and sampled by the next one.
  task automatic applyStimulus(input logic c0, input logic [3:0] w0, input logic [3:0] a0, input logic [31:0] v0,
                               input logic c1, input logic [3:0] w1, input logic [3:0] a1, input logic [31:0] v1);
    tce[0] = c0; twe[0] = w0; tad[0] = a0; td[0] = v0;
    tce[1] = c1; twe[1] = w1; tad[1] = a1; td[1] = v1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic waitClear(output int cnt);
    cnt = 0;
    while (dbusy[0] === 1'b1 && cnt < 40) begin
      idle(1);
      cnt++;
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [DEPTH];
  int          busy_cnt = 0;
  bit          model_on = 1'b0;
  int          edge_idx = 0;
  int          pend_due [NI][2][$];
  logic [31:0] pend_dat [NI][2][$];
  logic        exp_v [NI][2];
  logic [31:0] exp_q [NI][2];

  always @(posedge clk) begin : model_step
    logic [31:0] old_w [2];
    logic [31:0] rv;
    edge_idx++;
    if (rst) begin
      model_on = 1'b1;
      busy_cnt = DEPTH;
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < 2; p++) begin
          pend_due[i][p].delete();
          pend_dat[i][p].delete();
          exp_v[i][p] = 1'b0;
          exp_q[i][p] = 32'h0;
        end
      end
    end else if (model_on) begin
      if (busy_cnt > 0) begin
        mmem[DEPTH - busy_cnt] = 32'h0;
        busy_cnt--;
      end else begin
        for (int p = 0; p < 2; p++) old_w[p] = mmem[tad[p]];
        for (int i = 0; i < NI; i++) begin
          for (int p = 0; p < 2; p++) begin
            if (tce[p]) begin
              rv = old_w[p];
              if (i % 2 == 1) begin
                for (int l = 0; l < 4; l++) if (twe[p][l]) rv[l*8 +: 8] = td[p][l*8 +: 8];
              end
              pend_due[i][p].push_back(edge_idx + i);
              pend_dat[i][p].push_back(rv);
            end
          end
        end
        for (int l = 0; l < 4; l++) if (tce[1] && twe[1][l]) mmem[tad[1]][l*8 +: 8] = td[1][l*8 +: 8];
        for (int l = 0; l < 4; l++) if (tce[0] && twe[0][l]) mmem[tad[0]][l*8 +: 8] = td[0][l*8 +: 8];
      end
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (pend_due[i][p].size() > 0 && pend_due[i][p][0] == edge_idx) begin
            exp_v[i][p] = 1'b1;
            exp_q[i][p] = pend_dat[i][p].pop_front();
            void'(pend_due[i][p].pop_front());
          end else begin
            exp_v[i][p] = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("init_busy inst%0d t%0t", i, $time), 32'(dbusy[i]), 32'(busy_cnt > 0));
        for (int p = 0; p < 2; p++) begin
          checkOutput($sformatf("qvld%0d inst%0d t%0t", p, i, $time), 32'(dv[i][p]), 32'(exp_v[i][p]));
          checkOutput($sformatf("q%0d inst%0d t%0t", p, i, $time), dq[i][p], exp_q[i][p]);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  int cnt;
  int cnt_tot;
  int first_k [NI];

  initial begin
    tce[0] = 1'b0; twe[0] = 4'h0; tad[0] = 4'h0; td[0] = 32'h0;
    tce[1] = 1'b0; twe[1] = 4'h0; tad[1] = 4'h0; td[1] = 32'h0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checkOutput("q0 after reset", dq[0][0], 32'h0);
    checkOutput("qvld0 after reset", 32'(dv[0][0]), 32'h0);
    waitClear(cnt);
    checkOutput("initial clear length", cnt, 16);

    // garbage preload, then a single-cycle reset must re-zero everything
    for (int a = 0; a < 16; a++)
      applyStimulus(1'b1, 4'hF, 4'(a), 32'hDEAD0000 | a, 1'b1, 4'hF, 4'(15 - a), 32'hBEEF0000 | a);
    idle(2);
    pulseReset();
    checkOutput("init_busy after rst", 32'(dbusy[3]), 32'h1);
    waitClear(cnt);
    checkOutput("reset clear length", cnt, 16);
    for (int a = 0; a < 16; a++)
      applyStimulus(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(15 - a), 32'h0);
    idle(5);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("cleared q0 inst%0d", i), dq[i][0], 32'h0);
      checkOutput($sformatf("cleared q1 inst%0d", i), dq[i][1], 32'h0);
    end

    // reset mid-clear; ce during the new sweep must be ignored
    pulseReset();
    idle(5);
    pulseReset();
    idle(3);
    applyStimulus(1'b1, 4'hF, 4'h0, 32'hDEADBEEF, 1'b1, 4'h0, 4'h1, 32'h0);
    waitClear(cnt);
    cnt_tot = cnt + 4;
    checkOutput("mid-clear restart length", cnt_tot, 16);
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(5);
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("ce ignored in clear inst%0d", i), dq[i][0], 32'h0);

    // latency sweep
    for (int a = 0; a < 8; a++)
      applyStimulus(1'b1, 4'hF, 4'(a), 32'h1000 + a, 1'b1, 4'hF, 4'(8 + a), 32'h2000 + 8 + a);
    idle(5);
    for (int i = 0; i < NI; i++) first_k[i] = -1;
    applyStimulus(1'b1, 4'h0, 4'h2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NI; i++) if (dv[i][0] === 1'b1 && first_k[i] < 0) first_k[i] = k;
      idle(1);
    end
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("latency edges inst%0d", i), first_k[i], i);
      checkOutput($sformatf("latency data inst%0d", i), dq[i][0], 32'h1002);
    end
    for (int a = 0; a < 8; a++)
      applyStimulus(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(8 + a), 32'h0);
    idle(5);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("burst last q0 inst%0d", i), dq[i][0], 32'h1007);
      checkOutput($sformatf("burst last q1 inst%0d", i), dq[i][1], 32'h200F);
    end

    // read-during-write on port 0
    applyStimulus(1'b1, 4'hF, 4'h3, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 4'b0011, 4'h3, 32'h11223344, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(5);
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("rdw q0 inst%0d", i), dq[i][0], (i % 2 == 0) ? 32'hAABBCCDD : 32'hAABB3344);
    applyStimulus(1'b1, 4'h0, 4'h3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(5);
    checkOutput("rdw readback", dq[3][0], 32'hAABB3344);

    // cross-port lane collision
    applyStimulus(1'b1, 4'hF, 4'h5, 32'h12345678, 1'b0, 4'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 4'b0011, 4'h5, 32'h0000AAAA, 1'b1, 4'b0110, 4'h5, 32'h00BBBB00);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'h5, 32'h0);
    idle(5);
    checkOutput("collision result", dq[0][1], 32'h12BBAAAA);
    checkOutput("collision result L4", dq[3][1], 32'h12BBAAAA);

    // cross-port same-cycle write is old data to the other port
    applyStimulus(1'b1, 4'hF, 4'h7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 4'h0, 4'h7, 32'h0, 1'b1, 4'hF, 4'h7, 32'h5);
    idle(5);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("cross old q0 inst%0d", i), dq[i][0], 32'h0);
      checkOutput($sformatf("own write q1 inst%0d", i), dq[i][1], (i % 2 == 0) ? 32'h0 : 32'h5);
    end
    applyStimulus(1'b1, 4'h0, 4'h7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(5);
    checkOutput("cross new q0", dq[0][0], 32'h5);
    checkOutput("cross new q0 L3", dq[2][0], 32'h5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
